// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INIT/FETCH/EXEC/INTR control FSM with a
// return-address stack, branch/call/return and a single interrupt vector.
// Ports:
//   CLK, RST_N       clock, async active-low reset
//   PC_COUNT         current program counter value
//   BR_REQ/CALL_REQ/RET_REQ, TGT_ADDR   flow-control requests (EXEC only)
//   SEI/CLI          set/clear interrupt enable (EXEC only)
//   INTR             level-sensitive interrupt request
//   PC_RST/PC_LD/PC_INC, PC_DIN         program counter controls
//   IR_LD            instruction-register load strobe
//   IE, STK_ERR, STK_CNT, STATE         status
module pc_sequencer #(
  parameter int         STACK_DEPTH = 8,
  parameter logic [9:0] INTR_VECTOR = 10'h3FF
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] PC_COUNT,
  input  logic       BR_REQ,
  input  logic       CALL_REQ,
  input  logic       RET_REQ,
  input  logic [9:0] TGT_ADDR,
  input  logic       SEI,
  input  logic       CLI,
  input  logic       INTR,
  output logic       PC_RST,
  output logic       PC_LD,
  output logic       PC_INC,
  output logic [9:0] PC_DIN,
  output logic       IR_LD,
  output logic       IE,
  output logic       STK_ERR,
  output logic [4:0] STK_CNT,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_INTR  = 2'd3
  } state_t;

  localparam int         AW    = $clog2(STACK_DEPTH);
  localparam logic [4:0] DEPTH = 5'(STACK_DEPTH);

  state_t     st;
  state_t     st_nxt;
  logic       ie_nxt;
  logic       push;
  logic       pop;
  logic [9:0] push_val;
  logic [4:0] cnt;
  logic [4:0] top;
  logic       empty;
  logic       full;
  logic [9:0] stk [STACK_DEPTH];

  assign top     = cnt - 5'd1;
  assign empty   = (cnt == 5'd0);
  assign full    = (cnt >= DEPTH);
  assign STK_CNT = cnt;
  assign STATE   = st;

  always_comb begin
    PC_RST   = 1'b0;
    PC_LD    = 1'b0;
    PC_INC   = 1'b0;
    PC_DIN   = 10'd0;
    IR_LD    = 1'b0;
    STK_ERR  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    push_val = 10'd0;
    ie_nxt   = IE;
    st_nxt   = st;
    unique case (st)
      S_INIT: begin
        PC_RST = 1'b1;
        st_nxt = S_FETCH;
      end
      S_FETCH: begin
        IR_LD  = 1'b1;
        st_nxt = S_EXEC;
      end
      S_EXEC: begin
        ie_nxt = CLI ? 1'b0 : (SEI ? 1'b1 : IE);
        // interrupt decision uses the enable as updated this cycle
        st_nxt = (INTR && ie_nxt) ? S_INTR : S_FETCH;
        if (RET_REQ) begin
          if (empty) begin
            STK_ERR = 1'b1;
            PC_INC  = 1'b1;
          end else begin
            pop    = 1'b1;
            PC_LD  = 1'b1;
            PC_DIN = stk[top[AW-1:0]];
          end
        end else if (CALL_REQ) begin
          if (full) begin
            STK_ERR = 1'b1;
            PC_INC  = 1'b1;
          end else begin
            push     = 1'b1;
            push_val = PC_COUNT + 10'd1;
            PC_LD    = 1'b1;
            PC_DIN   = TGT_ADDR;
          end
        end else if (BR_REQ) begin
          PC_LD  = 1'b1;
          PC_DIN = TGT_ADDR;
        end else begin
          PC_INC = 1'b1;
        end
      end
      S_INTR: begin
        PC_LD  = 1'b1;
        PC_DIN = INTR_VECTOR;
        ie_nxt = 1'b0;
        st_nxt = S_FETCH;
        // vector regardless; only the resume push is lost when full
        if (full) begin
          STK_ERR = 1'b1;
        end else begin
          push     = 1'b1;
          push_val = PC_COUNT;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st  <= S_INIT;
      IE  <= 1'b0;
      cnt <= 5'd0;
    end else begin
      st <= st_nxt;
      IE <= ie_nxt;
      if (push) begin
        cnt <= cnt + 5'd1;
      end else if (pop) begin
        cnt <= cnt - 5'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      stk[cnt[AW-1:0]] <= push_val;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scenario tasks drive step tables,
// expected output vectors go through a scoreboard queue.
module tb_pc_sequencer;

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_INTR  = 2'd3;

  // output flag bits: rst ld inc ir err ie
  localparam logic [5:0] F_RST = 6'b100000;
  localparam logic [5:0] F_LD  = 6'b010000;
  localparam logic [5:0] F_INC = 6'b001000;
  localparam logic [5:0] F_IR  = 6'b000100;
  localparam logic [5:0] F_ERR = 6'b000010;
  localparam logic [5:0] F_IE  = 6'b000001;

  // stimulus bits: ret call br sei cli intr
  localparam logic [5:0] C_RET  = 6'b100000;
  localparam logic [5:0] C_CALL = 6'b010000;
  localparam logic [5:0] C_BR   = 6'b001000;
  localparam logic [5:0] C_SEI  = 6'b000100;
  localparam logic [5:0] C_CLI  = 6'b000010;
  localparam logic [5:0] C_INTR = 6'b000001;
  localparam logic [5:0] C_NONE = 6'b000000;

  typedef struct {
    logic [1:0]  s;
    logic [5:0]  c;
    logic [9:0]  pc;
    logic [9:0]  tgt;
    logic [22:0] e;
  } step_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] pc_count;
  logic       br_req;
  logic       call_req;
  logic       ret_req;
  logic [9:0] tgt_addr;
  logic       sei;
  logic       cli;
  logic       intr;
  logic       pc_rst;
  logic       pc_ld;
  logic       pc_inc;
  logic [9:0] pc_din;
  logic       ir_ld;
  logic       ie;
  logic       stk_err;
  logic [4:0] stk_cnt;
  logic [1:0] state;

  int checks;
  int failures;
  logic [22:0] sb [$];
  logic [22:0] obs;
  logic [22:0] e;

  assign obs = {state, pc_rst, pc_ld, pc_inc, ir_ld,
                stk_err, ie, stk_cnt, pc_din};

  pc_sequencer #(
    .STACK_DEPTH(8),
    .INTR_VECTOR(10'h3FF)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .PC_COUNT(pc_count),
    .BR_REQ  (br_req),
    .CALL_REQ(call_req),
    .RET_REQ (ret_req),
    .TGT_ADDR(tgt_addr),
    .SEI     (sei),
    .CLI     (cli),
    .INTR    (intr),
    .PC_RST  (pc_rst),
    .PC_LD   (pc_ld),
    .PC_INC  (pc_inc),
    .PC_DIN  (pc_din),
    .IR_LD   (ir_ld),
    .IE      (ie),
    .STK_ERR (stk_err),
    .STK_CNT (stk_cnt),
    .STATE   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [22:0] pk(input logic [1:0] s,
                                     input logic [5:0] f,
                                     input logic [4:0] c,
                                     input logic [9:0] d);
    return {s, f, c, d};
  endfunction

  function automatic step_t mk(input logic [1:0] s,
                               input logic [5:0] c,
                               input logic [9:0] pc,
                               input logic [9:0] tgt,
                               input logic [22:0] e_in);
    step_t r;
    r.s   = s;
    r.c   = c;
    r.pc  = pc;
    r.tgt = tgt;
    r.e   = e_in;
    return r;
  endfunction

  task automatic goto(input logic [1:0] s);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      {ret_req, call_req, br_req, sei, cli} = 5'b0;
      n++;
    end while (state !== s && n < 8);
    if (state !== s) begin
      checks++;
      failures++;
      $display("FAIL goto: state %0d want %0d", state, s);
    end
  endtask

  task automatic apply(input step_t st);
    goto(st.s);
    {ret_req, call_req, br_req, sei, cli, intr} = st.c;
    pc_count = st.pc;
    tgt_addr = st.tgt;
    sb.push_back(st.e);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    sb.push_back(pk(S_INIT, F_RST, 5'd0, 10'd0));
    #1 e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_hold: got %h want %h", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(pk(S_FETCH, F_IR, 5'd0, 10'd0));
    @(negedge clk);
    #1 e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_fetch: got %h want %h", obs, e);
    end
    apply(mk(S_EXEC, C_NONE, 10'h000, 10'h000,
             pk(S_EXEC, F_INC, 5'd0, 10'd0)));
    #1 e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL reset_exec: got %h want %h", obs, e);
    end
  endtask

  task automatic test_call_wrap;
    step_t t [$];
    t.push_back(mk(S_EXEC, C_CALL, 10'h3FF, 10'h010,
                   pk(S_EXEC, F_LD, 5'd0, 10'h010)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h010, 10'h000,
                   pk(S_FETCH, F_IR, 5'd1, 10'd0)));
    t.push_back(mk(S_EXEC, C_BR, 10'h010, 10'h155,
                   pk(S_EXEC, F_LD, 5'd1, 10'h155)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h155, 10'h000,
                   pk(S_FETCH, F_IR, 5'd1, 10'd0)));
    t.push_back(mk(S_EXEC, C_RET, 10'h155, 10'h000,
                   pk(S_EXEC, F_LD, 5'd1, 10'h000)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h000, 10'h000,
                   pk(S_FETCH, F_IR, 5'd0, 10'd0)));
    foreach (t[i]) begin
      apply(t[i]);
      #1 e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL call_wrap[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_overflow;
    step_t t [$];
    for (int i = 0; i < 8; i++) begin
      t.push_back(mk(S_EXEC, C_CALL, 10'(i * 37 + 5), 10'(i + 100),
                     pk(S_EXEC, F_LD, 5'(i), 10'(i + 100))));
    end
    t.push_back(mk(S_EXEC, C_CALL, 10'h200, 10'h111,
                   pk(S_EXEC, F_INC | F_ERR, 5'd8, 10'd0)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h201, 10'h000,
                   pk(S_FETCH, F_IR, 5'd8, 10'd0)));
    t.push_back(mk(S_EXEC, C_SEI, 10'h201, 10'h000,
                   pk(S_EXEC, F_INC, 5'd8, 10'd0)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h202, 10'h000,
                   pk(S_FETCH, F_IR | F_IE, 5'd8, 10'd0)));
    t.push_back(mk(S_EXEC, C_INTR, 10'h050, 10'h000,
                   pk(S_EXEC, F_INC | F_IE, 5'd8, 10'd0)));
    t.push_back(mk(S_INTR, C_INTR, 10'h051, 10'h000,
                   pk(S_INTR, F_LD | F_IE | F_ERR, 5'd8, 10'h3FF)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h3FF, 10'h000,
                   pk(S_FETCH, F_IR, 5'd8, 10'd0)));
    for (int i = 7; i >= 0; i--) begin
      t.push_back(mk(S_EXEC, C_RET, 10'h3FF, 10'h000,
                     pk(S_EXEC, F_LD, 5'(i + 1), 10'(i * 37 + 6))));
    end
    t.push_back(mk(S_EXEC, C_RET, 10'h006, 10'h000,
                   pk(S_EXEC, F_INC | F_ERR, 5'd0, 10'd0)));
    foreach (t[i]) begin
      apply(t[i]);
      #1 e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL overflow[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_intr;
    step_t t [$];
    t.push_back(mk(S_EXEC, C_SEI, 10'h020, 10'h000,
                   pk(S_EXEC, F_INC, 5'd0, 10'd0)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h021, 10'h000,
                   pk(S_FETCH, F_IR | F_IE, 5'd0, 10'd0)));
    t.push_back(mk(S_EXEC, C_INTR, 10'h024, 10'h000,
                   pk(S_EXEC, F_INC | F_IE, 5'd0, 10'd0)));
    t.push_back(mk(S_INTR, C_INTR, 10'h025, 10'h000,
                   pk(S_INTR, F_LD | F_IE, 5'd0, 10'h3FF)));
    t.push_back(mk(S_FETCH, C_INTR, 10'h3FF, 10'h000,
                   pk(S_FETCH, F_IR, 5'd1, 10'd0)));
    t.push_back(mk(S_EXEC, C_INTR, 10'h3FF, 10'h000,
                   pk(S_EXEC, F_INC, 5'd1, 10'd0)));
    t.push_back(mk(S_FETCH, C_INTR, 10'h000, 10'h000,
                   pk(S_FETCH, F_IR, 5'd1, 10'd0)));
    t.push_back(mk(S_EXEC, C_RET, 10'h000, 10'h000,
                   pk(S_EXEC, F_LD, 5'd1, 10'h025)));
    foreach (t[i]) begin
      apply(t[i]);
      #1 e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL intr[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_priority;
    step_t t [$];
    t.push_back(mk(S_EXEC, C_SEI, 10'h0F0, 10'h000,
                   pk(S_EXEC, F_INC, 5'd0, 10'd0)));
    t.push_back(mk(S_EXEC, C_CALL, 10'h100, 10'h200,
                   pk(S_EXEC, F_LD | F_IE, 5'd0, 10'h200)));
    t.push_back(mk(S_EXEC,
                   C_RET | C_CALL | C_BR | C_SEI | C_CLI,
                   10'h200, 10'h2AA,
                   pk(S_EXEC, F_LD | F_IE, 5'd1, 10'h101)));
    t.push_back(mk(S_FETCH, C_NONE, 10'h101, 10'h000,
                   pk(S_FETCH, F_IR, 5'd0, 10'd0)));
    t.push_back(mk(S_EXEC, C_INTR, 10'h300, 10'h000,
                   pk(S_EXEC, F_INC, 5'd0, 10'd0)));
    t.push_back(mk(S_FETCH, C_INTR, 10'h301, 10'h000,
                   pk(S_FETCH, F_IR, 5'd0, 10'd0)));
    foreach (t[i]) begin
      apply(t[i]);
      #1 e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL priority[%0d]: got %h want %h", i, obs, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    apply(mk(S_EXEC, C_CALL, 10'h040, 10'h080,
             pk(S_EXEC, F_LD, 5'd0, 10'h080)));
    #1 e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL mid_call1: got %h want %h", obs, e);
    end
    apply(mk(S_EXEC, C_CALL, 10'h081, 10'h090,
             pk(S_EXEC, F_LD, 5'd1, 10'h090)));
    #1 e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL mid_call2: got %h want %h", obs, e);
    end
    #1 rst_n = 1'b0;
    sb.push_back(pk(S_INIT, F_RST, 5'd0, 10'd0));
    #1 e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL mid_reset: got %h want %h", obs, e);
    end
    @(negedge clk);
    {ret_req, call_req, br_req, sei, cli, intr} = 6'b0;
    rst_n = 1'b1;
    sb.push_back(pk(S_FETCH, F_IR, 5'd0, 10'd0));
    @(negedge clk);
    #1 e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++;
      $display("FAIL mid_after: got %h want %h", obs, e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    pc_count = 10'd0;
    tgt_addr = 10'd0;
    {ret_req, call_req, br_req, sei, cli, intr} = 6'b0;
    test_reset();
    test_call_wrap();
    test_overflow();
    test_intr();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
